// File: rtl/mult_share_pkg.sv
// Shared constants and elaboration-time helpers for the shared multiply-add arbiter.
// Optional feature macro used by the design: MULT_SHARE_RR_EN (round-robin arbitration).
package mult_share_pkg;

  localparam int REP_UNSIGNED = 0;
  localparam int REP_SIGNED   = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width at which the multiply-add is evaluated before result formatting.
  function automatic int max_width(input int prod_w, input int sum_w);
    return (prod_w > sum_w) ? prod_w : sum_w;
  endfunction

endpackage

// File: rtl/mult_share_if.sv
// Request/result bundle between NREQ requesters, the shared multiplier and its consumer.
// Used unchanged whether or not MULT_SHARE_RR_EN is defined.
interface mult_share_if
  import mult_share_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTHA = 8,
  parameter int WIDTHB = 8,
  parameter int WIDTHS = 16,
  parameter int WIDTHP = 16
);
  localparam int IDW = clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WIDTHA-1:0] req_dataa;
  logic [NREQ*WIDTHB-1:0] req_datab;
  logic [NREQ*WIDTHS-1:0] req_sum;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTHP-1:0]      res_result;
  logic [IDW-1:0]         res_id;
  logic                   busy;

  modport master (
    output req_valid, req_dataa, req_datab, req_sum, res_ready,
    input  req_ready, res_valid, res_result, res_id, busy
  );

  modport slave (
    input  req_valid, req_dataa, req_datab, req_sum, res_ready,
    output req_ready, res_valid, res_result, res_id, busy
  );

endinterface

// File: rtl/mult_share_rr_arb.sv
// Requester arbiter: round-robin with a rotating pointer when MULT_SHARE_RR_EN is defined,
// otherwise stateless fixed priority (lowest index wins). Grants only while adv is high.
module mult_share_rr_arb
  import mult_share_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
`ifdef MULT_SHARE_RR_EN
  input  logic            clk,
  input  logic            reset,
`endif
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] sel;

`ifdef MULT_SHARE_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  int             j;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IDW'(j);
      end
    end
    ptr_d = ptr_q;
    if (adv && found) ptr_d = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        sel   = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (adv && found) grant[sel] = 1'b1;
    idx = sel;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// NREQ requesters share one two-stage multiply-add pipeline (S1 operands, S2 result).
// Arbitration policy selected by MULT_SHARE_RR_EN (defined: round-robin, else fixed priority).
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WIDTHA     = 8,
  parameter int WIDTHB     = 8,
  parameter int WIDTHS     = 16,
  parameter int WIDTHP     = 16,
  parameter int SIGNED_REP = REP_UNSIGNED
) (
  input logic        clk,
  input logic        reset,
  mult_share_if.slave bus
);

  localparam int IDW  = clog2(NREQ);
  localparam int MAXW = max_width(WIDTHA + WIDTHB, WIDTHS);

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTHA-1:0] s1_a_q, s1_a_d;
  logic [WIDTHB-1:0] s1_b_q, s1_b_d;
  logic [WIDTHS-1:0] s1_s_q, s1_s_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [WIDTHP-1:0] s2_result_q, s2_result_d;
  logic [IDW-1:0]    s2_id_q, s2_id_d;

  logic              s2_adv, s1_load, arb_adv;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    win_idx;
  logic [MAXW-1:0]   a_ext, b_ext, s_ext, p;
  logic [WIDTHP-1:0] res_calc;

  // S2 frees up when empty or consumed; S1 may load whenever it can move into S2.
  assign s2_adv  = !s2_valid_q || bus.res_ready;
  assign s1_load = !s1_valid_q || s2_adv;
  assign arb_adv = s1_load && !reset;

  mult_share_rr_arb #(.NREQ(NREQ)) u_arb (
`ifdef MULT_SHARE_RR_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   (bus.req_valid),
    .adv   (arb_adv),
    .grant (grant),
    .idx   (win_idx)
  );

  assign bus.req_ready = grant;

  always_comb begin
    if (SIGNED_REP == REP_SIGNED) begin
      a_ext = MAXW'(signed'(s1_a_q));
      b_ext = MAXW'(signed'(s1_b_q));
      s_ext = MAXW'(signed'(s1_s_q));
    end else begin
      a_ext = MAXW'(s1_a_q);
      b_ext = MAXW'(s1_b_q);
      s_ext = MAXW'(s1_s_q);
    end
    p = a_ext * b_ext + s_ext;
  end

  generate
    if (WIDTHP >= MAXW) begin : g_ext
      always_comb begin
        if (SIGNED_REP == REP_SIGNED) res_calc = WIDTHP'(signed'(p));
        else                          res_calc = WIDTHP'(p);
      end
    end else begin : g_trunc
      assign res_calc = WIDTHP'(p >> (MAXW - WIDTHP));
    end
  endgenerate

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_s_d      = s1_s_q;
    s1_id_d     = s1_id_q;
    if (s1_load) begin
      s1_valid_d = |grant;
      if (|grant) begin
        s1_a_d  = bus.req_dataa[win_idx*WIDTHA +: WIDTHA];
        s1_b_d  = bus.req_datab[win_idx*WIDTHB +: WIDTHB];
        s1_s_d  = bus.req_sum[win_idx*WIDTHS +: WIDTHS];
        s1_id_d = win_idx;
      end
    end

    // Data fields keep their old value when S2 drains empty, so outputs never glitch.
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_id_d     = s2_id_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = res_calc;
        s2_id_d     = s1_id_q;
      end
    end
  end

  // NOTE: only a handful of pipeline registers, so all of them (data included) are reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_s_q      <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_id_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_s_q      <= s1_s_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_id_q     <= s2_id_d;
    end
  end

  assign bus.res_valid  = s2_valid_q;
  assign bus.res_result = s2_result_q;
  assign bus.res_id     = s2_id_q;
  assign bus.busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench: unsigned, signed and truncating instances share one stimulus; expected
// values are hand-computed. Arbitration expectations follow MULT_SHARE_RR_EN.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_dataa;
  logic [31:0] req_datab;
  logic [63:0] req_sum;
  logic        res_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_share_if #(.NREQ(4), .WIDTHP(16)) bus_u ();
  mult_share_if #(.NREQ(4), .WIDTHP(16)) bus_s ();
  mult_share_if #(.NREQ(4), .WIDTHP(8))  bus_t ();

  assign bus_u.req_valid = req_valid;
  assign bus_u.req_dataa = req_dataa;
  assign bus_u.req_datab = req_datab;
  assign bus_u.req_sum   = req_sum;
  assign bus_u.res_ready = res_ready;
  assign bus_s.req_valid = req_valid;
  assign bus_s.req_dataa = req_dataa;
  assign bus_s.req_datab = req_datab;
  assign bus_s.req_sum   = req_sum;
  assign bus_s.res_ready = res_ready;
  assign bus_t.req_valid = req_valid;
  assign bus_t.req_dataa = req_dataa;
  assign bus_t.req_datab = req_datab;
  assign bus_t.req_sum   = req_sum;
  assign bus_t.res_ready = res_ready;

  mult_share_arbiter #(.NREQ(4), .WIDTHP(16), .SIGNED_REP(0)) u_uns (
    .clk(clk), .reset(reset), .bus(bus_u));
  mult_share_arbiter #(.NREQ(4), .WIDTHP(16), .SIGNED_REP(1)) u_sgn (
    .clk(clk), .reset(reset), .bus(bus_s));
  mult_share_arbiter #(.NREQ(4), .WIDTHP(8), .SIGNED_REP(0)) u_trn (
    .clk(clk), .reset(reset), .bus(bus_t));

  typedef struct {
    int          r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] s;
    logic [15:0] exp_u;
    logic [15:0] exp_s;
    logic [7:0]  exp_t;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int r, input logic [7:0] a, input logic [7:0] b, input logic [15:0] s);
    req_valid[r]          = 1'b1;
    req_dataa[r*8 +: 8]   = a;
    req_datab[r*8 +: 8]   = b;
    req_sum[r*16 +: 16]   = s;
  endtask

  initial begin
    int exp_g;

    vecs[0] = '{0, 8'h03, 8'h05, 16'h0002, 16'h0011, 16'h0011, 8'h00};
    vecs[1] = '{1, 8'hFE, 8'h03, 16'h0001, 16'h02FB, 16'hFFFB, 8'h02};
    vecs[2] = '{2, 8'hFF, 8'hFF, 16'h0000, 16'hFE01, 16'h0001, 8'hFE};
    vecs[3] = '{3, 8'h80, 8'h80, 16'h1234, 16'h5234, 16'h5234, 8'h52};
    vecs[4] = '{0, 8'h7F, 8'h81, 16'hFFFF, 16'h3FFE, 16'hC0FE, 8'h3F};
    vecs[5] = '{2, 8'h00, 8'hAB, 16'hBEEF, 16'hBEEF, 16'hBEEF, 8'hBE};

    // Reset state, with every requester asking during reset.
    reset     = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'hF;
    req_dataa = '0;
    req_datab = '0;
    req_sum   = '0;
    repeat (2) tick();
    check("rst_req_ready", 32'(bus_u.req_ready), 32'h0);
    check("rst_res_valid", 32'(bus_u.res_valid), 32'h0);
    check("rst_busy", 32'(bus_u.busy), 32'h0);
    check("rst_res_result", 32'(bus_u.res_result), 32'h0);
    check("rst_res_id", 32'(bus_u.res_id), 32'h0);
    req_valid = '0;
    reset     = 1'b0;
    #1;
    check("idle_no_grant", 32'(bus_u.req_ready), 32'h0);
    tick();
    check("idle_busy", 32'(bus_u.busy), 32'h0);

    // Single-request vectors: latency, id and result formatting for all three builds.
    for (int i = 0; i < 6; i++) begin
      put(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].s);
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus_u.req_ready), 32'(4'b1 << vecs[i].r));
      tick();
      req_valid = '0;
      check($sformatf("v%0d_lat1_valid", i), 32'(bus_u.res_valid), 32'h0);
      check($sformatf("v%0d_lat1_busy", i), 32'(bus_u.busy), 32'h1);
      tick();
      check($sformatf("v%0d_valid", i), 32'(bus_u.res_valid), 32'h1);
      check($sformatf("v%0d_uns", i), 32'(bus_u.res_result), 32'(vecs[i].exp_u));
      check($sformatf("v%0d_id", i), 32'(bus_u.res_id), 32'(vecs[i].r));
      check($sformatf("v%0d_sgn", i), 32'(bus_s.res_result), 32'(vecs[i].exp_s));
      check($sformatf("v%0d_trn", i), 32'(bus_t.res_result), 32'(vecs[i].exp_t));
      tick();
    end
    check("drain_valid", 32'(bus_u.res_valid), 32'h0);

    // All requesters valid continuously from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) put(r, 8'(r + 1), 8'h02, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      #1;
`ifdef MULT_SHARE_RR_EN
      exp_g = k % 4;
`else
      exp_g = 0;
`endif
      check($sformatf("arb_grant%0d", k), 32'(bus_u.req_ready), 32'(4'b1 << exp_g));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: hold two accepted results, then release.
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    res_ready = 1'b0;
    put(1, 8'h02, 8'h03, 16'h0000);
    #1;
    check("bp_ready1", 32'(bus_u.req_ready), 32'h2);
    tick();
    req_valid = '0;
    put(2, 8'h04, 8'h05, 16'h0001);
    #1;
    check("bp_ready2", 32'(bus_u.req_ready), 32'h4);
    tick();
    req_valid = '0;
    put(3, 8'h09, 8'h09, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_hold%0d_valid", k), 32'(bus_u.res_valid), 32'h1);
      check($sformatf("bp_hold%0d_result", k), 32'(bus_u.res_result), 32'd6);
      check($sformatf("bp_hold%0d_id", k), 32'(bus_u.res_id), 32'd1);
      check($sformatf("bp_hold%0d_ready", k), 32'(bus_u.req_ready), 32'h0);
      check($sformatf("bp_hold%0d_busy", k), 32'(bus_u.busy), 32'h1);
      if (k < 2) tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    check("bp_rel1_valid", 32'(bus_u.res_valid), 32'h1);
    check("bp_rel1_result", 32'(bus_u.res_result), 32'd21);
    check("bp_rel1_id", 32'(bus_u.res_id), 32'd2);
    tick();
    check("bp_rel2_valid", 32'(bus_u.res_valid), 32'h0);
    check("bp_rel2_busy", 32'(bus_u.busy), 32'h0);

    // Reset with both stages full; nothing stale may surface afterwards.
    put(0, 8'h07, 8'h07, 16'h0000);
    tick();
    req_valid = '0;
    put(1, 8'h06, 8'h06, 16'h0000);
    tick();
    req_valid = '0;
    check("full_busy", 32'(bus_u.busy), 32'h1);
    check("full_valid", 32'(bus_u.res_valid), 32'h1);
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(bus_u.res_valid), 32'h0);
    check("midrst_busy", 32'(bus_u.busy), 32'h0);
    check("midrst_result", 32'(bus_u.res_result), 32'h0);
    check("midrst_id", 32'(bus_u.res_id), 32'h0);
    reset = 1'b0;
    put(2, 8'h03, 8'h03, 16'h0000);
    #1;
    check("postrst_ready", 32'(bus_u.req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("postrst_nostale", 32'(bus_u.res_valid), 32'h0);
    tick();
    check("postrst_valid", 32'(bus_u.res_valid), 32'h1);
    check("postrst_result", 32'(bus_u.res_result), 32'd9);
    check("postrst_id", 32'(bus_u.res_id), 32'd2);
    tick();
    check("postrst_drain", 32'(bus_u.res_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter WIDTHA, default 8, dataa operand width.
REQ-003 SHALL have parameter WIDTHB, default 8, datab operand width.
REQ-004 SHALL have parameter WIDTHS, default 16, addend (sum) width.
REQ-005 SHALL have parameter WIDTHP, default 16, result width.
REQ-006 SHALL have parameter SIGNED_REP, default 0, where 0 means unsigned and 1 means two's-complement operands.
REQ-007 SHALL have port clk, in, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-009 SHALL have port req_valid, in, NREQ, per-requester operand valid.
REQ-010 SHALL have port req_ready, out, NREQ, per-requester accept; at most one bit high per cycle.
REQ-011 SHALL have ports req_dataa, in, NREQ*WIDTHA; req_datab, in, NREQ*WIDTHB; req_sum, in, NREQ*WIDTHS. Each is packed, with requester i in slice i.
REQ-012 SHALL have port res_valid, out, 1, result available.
REQ-013 SHALL have port res_ready, in, 1, consumer accepts the result.
REQ-014 SHALL have port res_result, out, WIDTHP, multiply-add result.
REQ-015 SHALL have port res_id, out, clog2(NREQ), index of the requester that owns res_result.
REQ-016 SHALL have port busy, out, 1, high while any operation is in stage 1 or stage 2.

Function
REQ-017 SHALL transfer a request on requester i only in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 SHALL assert req_ready only to the arbitration winner, and only when stage 1 is empty or stage 1 advances in the same cycle.
REQ-019 SHALL use a two-stage pipeline:
- S1 registers the winning operands and id.
- S2 registers the computed result and id, and drives res_*.
REQ-020 SHALL give a latency of 2 cycles from accept to res_valid when there is no backpressure, and sustain one result per cycle.
REQ-021 SHALL hold S2 while res_valid=1 and res_ready=0, and hold S1 when S2 is held. Held outputs SHALL remain stable.
REQ-022 SHALL let S2 load a new result in the same cycle the old one is consumed, with no bubble.
REQ-023 SHALL compute p = dataa*datab + sum at MAXW = max(WIDTHA+WIDTHB, WIDTHS) bits, modulo 2^MAXW, with operands interpreted per SIGNED_REP.
REQ-024 SHALL form res_result as follows:
- If WIDTHP >= MAXW, p extended (sign-extended if SIGNED_REP=1, zero-extended otherwise).
- Otherwise, the WIDTHP most significant bits of p.
REQ-025 SHALL never drop or duplicate a request; a requester whose valid is high and not granted keeps its operands stable.
REQ-026 SHALL perform no grant in a cycle where req_valid is all zero.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, clear S1 and S2, set res_valid=0, req_ready=0, busy=0, res_result=0 and res_id=0, and set the arbitration pointer to 0.
REQ-028 SHALL discard in-flight operations if reset is asserted mid-operation; no result from them is ever presented.
REQ-029 SHALL accept requests from the first cycle after reset deasserts.

Configuration
REQ-030 SHALL use round-robin arbitration when MULT_SHARE_RR_EN is defined: after a grant to i, the highest priority becomes (i+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-031 SHALL use fixed priority when MULT_SHARE_RR_EN is undefined: the lowest asserted index wins and no pointer register exists.

Structure
REQ-032 SHALL place the following in package mult_share_pkg:
- REP_UNSIGNED and REP_SIGNED constants.
- The clog2 function.
- The max-width function computing MAXW.
REQ-033 SHALL implement arbitration in sub-module mult_share_rr_arb: inputs are the request vector and an advance strobe; outputs are the one-hot grant and the index.
REQ-034 SHALL implement the multiply-add datapath inline between S1 and S2, with no further sub-modules.

Verification
REQ-035 Unsigned, NREQ=4, req0 a=3 b=5 s=2, res_ready=1 -> res_valid 2 cycles after accept, res_result=17, res_id=0.
REQ-036 SIGNED_REP=1, a=8'hFE(-2) b=8'h03 s=16'h0001 -> res_result=16'hFFFB (-5).
REQ-037 MULT_SHARE_RR_EN defined, all 4 valid continuously -> grants 0,1,2,3,0 on consecutive cycles. Undefined -> grant 0 every cycle.
REQ-038 Hold res_ready=0 for 3 cycles with two requests accepted -> S2 result stable, S1 holds, req_ready=0; on release the two results arrive on consecutive cycles in order.
REQ-039 WIDTHP=8, MAXW=16, a=b=8'hFF s=0 -> res_result=8'hFE, the top byte of 16'hFE01.
REQ-040 Assert reset with S1 and S2 full -> next cycle res_valid=0, busy=0, and no stale result ever appears.
